spi_flash_status_slave: RTL and testbench

// SPI mode-0 responder emulating a serial flash status register, the target end of the flash RDSR/WREN master.

---
 rtl/spi_flash_status_slave.sv | 197 +++++++++++++++++++
 tb/tb_spi_flash_status_slave.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_flash_status_slave.sv
// SPI mode-0 target that emulates a serial flash status register (RDSR/WREN/WRDI/WRSR)
// with a modelled write-in-progress busy time. All SPI pins are oversampled on sys_clk.
module spi_flash_status_slave #(
    parameter int BUSY_CYCLES = 1000
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic       spi_sck,
    input  logic       spi_cs_n,
    input  logic       spi_mosi,
    output logic       spi_miso,
    input  logic       busy_req,
    output logic       cmd_valid,
    output logic [7:0] cmd_code,
    output logic [7:0] status_out,
    output logic       busy
);
    localparam int CW = $clog2(BUSY_CYCLES + 1);
    localparam logic [CW-1:0] BUSY_LOAD = CW'(BUSY_CYCLES);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_OPCODE   = 3'd1;
    localparam logic [2:0] ST_RDSR_OUT = 3'd2;
    localparam logic [2:0] ST_WRSR_IN  = 3'd3;
    localparam logic [2:0] ST_CMD_DONE = 3'd4;
    localparam logic [2:0] ST_IGNORE   = 3'd5;

    localparam logic [7:0] OP_WRSR = 8'h01;
    localparam logic [7:0] OP_WRDI = 8'h04;
    localparam logic [7:0] OP_RDSR = 8'h05;
    localparam logic [7:0] OP_WREN = 8'h06;

    // Synchronizer vectors: bit0 = SCK, bit1 = CS_n, bit2 = MOSI (MOSI needs no history stage).
    logic [2:0] sync_s1_q, sync_s2_q;
    logic [1:0] sync_s3_q;

    logic [2:0]    state_q, state_d;
    logic [4:0]    bit_cnt_q, bit_cnt_d;
    logic [2:0]    out_cnt_q, out_cnt_d;
    logic [7:0]    rx_q, rx_d;
    logic [6:0]    tx_q, tx_d;
    logic          miso_q, miso_d;
    logic          cmd_valid_q, cmd_valid_d;
    logic [7:0]    cmd_code_q, cmd_code_d;
    logic          srwd_q, srwd_d;
    logic [2:0]    bp_q, bp_d;
    logic          wel_q, wel_d;
    logic          wip_q, wip_d;
    logic [CW-1:0] busy_cnt_q, busy_cnt_d;

    logic       sck_rise, sck_fall, cs_rise, cs_fall, cs_high, mosi_sync;
    logic [7:0] rx_shift;
    logic [7:0] status_live;

    assign sck_rise  = sync_s2_q[0] & ~sync_s3_q[0];
    assign sck_fall  = ~sync_s2_q[0] & sync_s3_q[0];
    assign cs_rise   = sync_s2_q[1] & ~sync_s3_q[1];
    assign cs_fall   = ~sync_s2_q[1] & sync_s3_q[1];
    assign cs_high   = sync_s2_q[1];
    assign mosi_sync = sync_s2_q[2];
    assign rx_shift  = {rx_q[6:0], mosi_sync};

    assign status_live = {srwd_q, 2'b00, bp_q, wel_q, wip_q};

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            sync_s1_q <= 3'b010;
            sync_s2_q <= 3'b010;
            sync_s3_q <= 2'b10;
        end else begin
            sync_s1_q <= {spi_mosi, spi_cs_n, spi_sck};
            sync_s2_q <= sync_s1_q;
            sync_s3_q <= sync_s2_q[1:0];
        end
    end

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        out_cnt_d   = out_cnt_q;
        rx_d        = rx_q;
        tx_d        = tx_q;
        miso_d      = miso_q;
        cmd_valid_d = 1'b0;
        cmd_code_d  = cmd_code_q;
        srwd_d      = srwd_q;
        bp_d        = bp_q;
        wel_d       = wel_q;
        wip_d       = wip_q;
        busy_cnt_d  = busy_cnt_q;

        // Busy timer; a completed program/erase also drops the write-enable latch.
        if (wip_q) begin
            if (busy_cnt_q > CNT_ONE) begin
                busy_cnt_d = busy_cnt_q - CNT_ONE;
            end else begin
                busy_cnt_d = '0;
                wip_d      = 1'b0;
                wel_d      = 1'b0;
            end
        end else if (busy_req) begin
            wip_d      = 1'b1;
            busy_cnt_d = BUSY_LOAD;
        end

        if (cs_high) begin
            state_d   = ST_IDLE;
            bit_cnt_d = '0;
            out_cnt_d = '0;
            miso_d    = 1'b0;
            if (cs_rise) begin
                if (state_q == ST_CMD_DONE && bit_cnt_q == 5'd8) begin
                    wel_d = (cmd_code_q == OP_WREN);
                end
                // WRSR load overrides any busy_req load made above in the same cycle.
                if (state_q == ST_WRSR_IN && bit_cnt_q == 5'd16 && wel_q) begin
                    srwd_d     = rx_q[7];
                    bp_d       = rx_q[4:2];
                    wip_d      = 1'b1;
                    busy_cnt_d = BUSY_LOAD;
                end
            end
        end else if (cs_fall) begin
            state_d   = ST_OPCODE;
            bit_cnt_d = '0;
            out_cnt_d = '0;
        end else if (state_q != ST_IDLE) begin
            if (sck_rise) begin
                rx_d = rx_shift;
                if (bit_cnt_q != 5'd31) begin
                    bit_cnt_d = bit_cnt_q + 5'd1;
                end
                if (state_q == ST_OPCODE && bit_cnt_q == 5'd7) begin
                    cmd_valid_d = 1'b1;
                    cmd_code_d  = rx_shift;
                    case (rx_shift)
                        OP_RDSR:          state_d = ST_RDSR_OUT;
                        OP_WREN, OP_WRDI: state_d = wip_q ? ST_IGNORE : ST_CMD_DONE;
                        OP_WRSR:          state_d = wip_q ? ST_IGNORE : ST_WRSR_IN;
                        default:          state_d = ST_IGNORE;
                    endcase
                end
            end
            // Each new byte re-snapshots the live status so polling in one frame sees updates.
            if (sck_fall && state_q == ST_RDSR_OUT) begin
                out_cnt_d = out_cnt_q + 3'd1;
                if (out_cnt_q == 3'd0) begin
                    tx_d   = status_live[6:0];
                    miso_d = status_live[7];
                end else begin
                    tx_d   = {tx_q[5:0], 1'b0};
                    miso_d = tx_q[6];
                end
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= '0;
            out_cnt_q   <= '0;
            rx_q        <= '0;
            tx_q        <= '0;
            miso_q      <= 1'b0;
            cmd_valid_q <= 1'b0;
            cmd_code_q  <= '0;
            srwd_q      <= 1'b0;
            bp_q        <= '0;
            wel_q       <= 1'b0;
            wip_q       <= 1'b0;
            busy_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            out_cnt_q   <= out_cnt_d;
            rx_q        <= rx_d;
            tx_q        <= tx_d;
            miso_q      <= miso_d;
            cmd_valid_q <= cmd_valid_d;
            cmd_code_q  <= cmd_code_d;
            srwd_q      <= srwd_d;
            bp_q        <= bp_d;
            wel_q       <= wel_d;
            wip_q       <= wip_d;
            busy_cnt_q  <= busy_cnt_d;
        end
    end

    assign spi_miso   = miso_q;
    assign cmd_valid  = cmd_valid_q;
    assign cmd_code   = cmd_code_q;
    assign status_out = status_live;
    assign busy       = wip_q;

endmodule

// File: tb/tb_spi_flash_status_slave.sv
// Directed bench for spi_flash_status_slave: an SPI mode-0 master drives frames with HALF=5
// and every observed value is checked against hand-computed expectations.
module tb_spi_flash_status_slave;
    localparam int HALF = 5;
    localparam int BUSY = 40;

    logic       sys_clk;
    logic       sys_rst;
    logic       spi_sck;
    logic       spi_cs_n;
    logic       spi_mosi;
    logic       spi_miso;
    logic       busy_req;
    logic       cmd_valid;
    logic [7:0] cmd_code;
    logic [7:0] status_out;
    logic       busy;

    int n_checks = 0;
    int n_fails  = 0;
    int cv_count = 0;
    logic [7:0] cv_last = 8'h00;

    spi_flash_status_slave #(.BUSY_CYCLES(BUSY)) dut (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .spi_sck   (spi_sck),
        .spi_cs_n  (spi_cs_n),
        .spi_mosi  (spi_mosi),
        .spi_miso  (spi_miso),
        .busy_req  (busy_req),
        .cmd_valid (cmd_valid),
        .cmd_code  (cmd_code),
        .status_out(status_out),
        .busy      (busy)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    // Opcode pulse monitor: counts high cycles of cmd_valid and keeps the code seen with it.
    always @(negedge sys_clk) begin
        if (cmd_valid === 1'b1) begin
            cv_count = cv_count + 1;
            cv_last  = cmd_code;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    task automatic xfer_bit(input logic b, output logic r);
        spi_mosi = b;
        wait_clk(HALF);
        spi_sck = 1'b1;
        r = spi_miso;
        wait_clk(HALF);
        spi_sck = 1'b0;
    endtask

    task automatic xfer_byte(input logic [7:0] tx, output logic [7:0] rx);
        logic r;
        rx = 8'h00;
        for (int i = 7; i >= 0; i--) begin
            xfer_bit(tx[i], r);
            rx[i] = r;
        end
    endtask

    task automatic cs_begin();
        spi_cs_n = 1'b0;
        wait_clk(HALF);
    endtask

    task automatic cs_end(input int hold);
        wait_clk(hold);
        spi_cs_n = 1'b1;
        wait_clk(8);
    endtask

    task automatic frame1(input logic [7:0] op);
        logic [7:0] d;
        cs_begin();
        xfer_byte(op, d);
        cs_end(HALF);
    endtask

    task automatic rdsr(output logic [7:0] st);
        logic [7:0] d;
        cs_begin();
        xfer_byte(8'h05, d);
        xfer_byte(8'h00, st);
        cs_end(HALF);
    endtask

    task automatic pulse_busy_req();
        busy_req = 1'b1;
        wait_clk(1);
        busy_req = 1'b0;
    endtask

    initial begin
        logic [7:0] st;
        logic [7:0] d;
        logic       r;
        int         base;
        int         cyc;

        sys_rst  = 1'b1;
        spi_sck  = 1'b0;
        spi_cs_n = 1'b1;
        spi_mosi = 1'b0;
        busy_req = 1'b0;
        wait_clk(4);
        check("rst_status", status_out, 8'h00);
        check("rst_busy", busy, 1'b0);
        check("rst_miso", spi_miso, 1'b0);
        check("rst_cmd_valid", cmd_valid, 1'b0);
        check("rst_cmd_code", cmd_code, 8'h00);
        sys_rst = 1'b0;
        wait_clk(4);

        // 1: plain RDSR after reset
        base = cv_count;
        rdsr(st);
        check("t1_rdsr", st, 8'h00);
        check("t1_cv_pulses", cv_count - base, 1);
        check("t1_cv_code", cv_last, 8'h05);

        // 2: WREN sets WEL, WRDI clears it
        frame1(8'h06);
        check("t2_status_wren", status_out, 8'h02);
        rdsr(st);
        check("t2_rdsr_wren", st, 8'h02);
        frame1(8'h04);
        rdsr(st);
        check("t2_rdsr_wrdi", st, 8'h00);

        // 3: WREN + WRSR 9C, exact busy length then WEL dropped
        frame1(8'h06);
        cs_begin();
        xfer_byte(8'h01, d);
        xfer_byte(8'h9C, d);
        wait_clk(HALF);
        spi_cs_n = 1'b1;
        for (int i = 0; i < 20 && busy !== 1'b1; i++) wait_clk(1);
        check("t3_busy_start", busy, 1'b1);
        check("t3_status_busy", status_out, 8'h9F);
        cyc = 0;
        while (busy === 1'b1 && cyc < 200) begin
            cyc++;
            wait_clk(1);
        end
        check("t3_busy_cycles", cyc, BUSY);
        check("t3_status_done", status_out, 8'h9C);
        check("t3_busy_done", busy, 1'b0);
        rdsr(st);
        check("t3_rdsr_done", st, 8'h9C);

        // 4: WRSR without WREN, aborted WREN, over-long WREN
        sys_rst = 1'b1;
        wait_clk(2);
        sys_rst = 1'b0;
        wait_clk(4);
        cs_begin();
        xfer_byte(8'h01, d);
        xfer_byte(8'h9C, d);
        cs_end(HALF);
        check("t4_wrsr_no_wel", status_out, 8'h00);
        rdsr(st);
        check("t4_rdsr", st, 8'h00);
        cs_begin();
        for (int i = 7; i >= 3; i--) xfer_bit(1'b0, r);
        cs_end(HALF);
        check("t4_wren_5bits", status_out, 8'h00);
        cs_begin();
        xfer_byte(8'h06, d);
        xfer_bit(1'b0, r);
        cs_end(HALF);
        check("t4_wren_9bits", status_out, 8'h00);
        frame1(8'h06);
        check("t4_wren_ok", status_out, 8'h02);
        frame1(8'h04);

        // 5: busy_req late in the opcode, status stream tracks expiry
        cs_begin();
        for (int i = 7; i >= 1; i--) xfer_bit(i == 2, r);
        pulse_busy_req();
        check("t5_busy_req", busy, 1'b1);
        xfer_bit(1'b1, r);
        xfer_byte(8'h00, st);
        check("t5_byte0", st, 8'h01);
        xfer_byte(8'h00, st);
        check("t5_byte1", st, 8'h00);
        xfer_byte(8'h00, st);
        check("t5_byte2", st, 8'h00);
        cs_end(HALF);

        // 6: WREN while WIP=1 is ignored; CS held past expiry so a wrong commit would stick
        base = cv_count;
        cs_begin();
        for (int i = 7; i >= 3; i--) xfer_bit(1'b0, r);
        pulse_busy_req();
        xfer_bit(1'b1, r);
        xfer_bit(1'b1, r);
        xfer_bit(1'b0, r);
        check("t6_busy_during", busy, 1'b1);
        cs_end(60);
        check("t6_cv_code", cv_last, 8'h06);
        check("t6_cv_pulses", cv_count - base, 1);
        check("t6_wren_ignored", status_out, 8'h00);

        // 6b: reset in the middle of an RDSR data byte
        frame1(8'h06);
        check("t6_wel_set", status_out, 8'h02);
        cs_begin();
        xfer_byte(8'h05, d);
        for (int i = 0; i < 6; i++) xfer_bit(1'b0, r);
        wait_clk(4);
        check("t6_miso_pre_rst", spi_miso, 1'b1);
        sys_rst = 1'b1;
        wait_clk(1);
        check("t6_rst_status", status_out, 8'h00);
        check("t6_rst_miso", spi_miso, 1'b0);
        check("t6_rst_busy", busy, 1'b0);
        sys_rst = 1'b0;
        spi_cs_n = 1'b1;
        wait_clk(8);
        rdsr(st);
        check("t6_rdsr_after_rst", st, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
